// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor: counts rising edges on three input-neuron spike lines and
// the output-neuron spike line over a fixed window of WINDOW_CYCLES clocks.
// At the end of each window it latches the per-line counts and the index of
// the most active input neuron, and pulses result_valid for one cycle.
// Optional rate alarm on the output-neuron count: define SPIKE_RATE_ALARM_EN.
module spike_rate_monitor #(
  parameter int unsigned WINDOW_CYCLES = 64,
  parameter int unsigned COUNT_W       = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               spike_1,
  input  logic               spike_2,
  input  logic               spike_3,
  input  logic               spike_output,
  output logic [COUNT_W-1:0] in_count_1,
  output logic [COUNT_W-1:0] in_count_2,
  output logic [COUNT_W-1:0] in_count_3,
  output logic [COUNT_W-1:0] out_count,
  output logic [1:0]         winner,
  output logic               result_valid,
  output logic               busy
`ifdef SPIKE_RATE_ALARM_EN
  ,
  input  logic [COUNT_W-1:0] rate_thresh,
  output logic               rate_alarm
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [15:0]        WLAST   = 16'(WINDOW_CYCLES - 1);

  state_t             state_q;
  logic [15:0]        wcnt_q;
  logic [3:0]         spk;
  logic [3:0]         prev_q;
  logic [3:0]         ev;
  logic [COUNT_W-1:0] cnt_q [4];
  logic [COUNT_W-1:0] cnt_d [4];
  logic [COUNT_W-1:0] lat_q [4];
  logic [1:0]         winner_d;
  logic [1:0]         winner_q;
  logic               rv_q;
`ifdef SPIKE_RATE_ALARM_EN
  logic               alarm_q;
`endif

  // Line order: index 0..2 = input neurons 1..3, index 3 = output neuron.
  assign spk = {spike_output, spike_3, spike_2, spike_1};
  assign ev  = spk & ~prev_q;

  // Saturating increment of each working counter on a rising-edge event.
  for (genvar g = 0; g < 4; g++) begin : g_inc
    assign cnt_d[g] = (ev[g] && (cnt_q[g] != CNT_MAX)) ? cnt_q[g] + 1'b1 : cnt_q[g];
  end

  // Argmax over the three input counts including this cycle's events;
  // ties resolve to the lowest index, all-zero gives 0.
  always_comb begin
    winner_d = 2'd0;
    if ((cnt_d[0] != '0) && (cnt_d[0] >= cnt_d[1]) && (cnt_d[0] >= cnt_d[2])) begin
      winner_d = 2'd1;
    end else if ((cnt_d[1] != '0) && (cnt_d[1] >= cnt_d[2])) begin
      winner_d = 2'd2;
    end else if (cnt_d[2] != '0) begin
      winner_d = 2'd3;
    end
  end

  // Previous-value registers for edge detection, updated in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= spk;
    end
  end

  // Window sequencer: IDLE -> COUNT (WINDOW_CYCLES cycles) -> REPORT (1 cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      cnt_q    <= '{default: '0};
      lat_q    <= '{default: '0};
      winner_q <= 2'd0;
      rv_q     <= 1'b0;
`ifdef SPIKE_RATE_ALARM_EN
      alarm_q  <= 1'b0;
`endif
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wcnt_q <= '0;
          cnt_q  <= '{default: '0};
          if (enable) begin
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!enable) begin
            // Abort discards the partial window; latched results stay intact.
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            cnt_q   <= '{default: '0};
          end else if (wcnt_q == WLAST) begin
            // Final-cycle events are folded in via cnt_d before latching.
            lat_q    <= cnt_d;
            winner_q <= winner_d;
            cnt_q    <= '{default: '0};
            wcnt_q   <= '0;
            rv_q     <= 1'b1;
            state_q  <= S_REPORT;
`ifdef SPIKE_RATE_ALARM_EN
            alarm_q  <= (cnt_d[3] >= rate_thresh) && (rate_thresh != '0);
`endif
          end else begin
            cnt_q  <= cnt_d;
            wcnt_q <= wcnt_q + 16'd1;
          end
        end
        S_REPORT: begin
          state_q <= enable ? S_COUNT : S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_count_1   = lat_q[0];
  assign in_count_2   = lat_q[1];
  assign in_count_3   = lat_q[2];
  assign out_count    = lat_q[3];
  assign winner       = winner_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != S_IDLE);
`ifdef SPIKE_RATE_ALARM_EN
  assign rate_alarm   = alarm_q;
`endif

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor: instance A (16-cycle window, 6-bit
// counts) and instance B (32-cycle window, 3-bit counts) share clock and reset.
module tb_spike_rate_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_a, s1_a, s2_a, s3_a, so_a;
  logic [5:0] c1_a, c2_a, c3_a, co_a;
  logic [1:0] win_a;
  logic       rv_a, busy_a;
  logic       en_b, s1_b, s2_b, s3_b, so_b;
  logic [2:0] c1_b, c2_b, c3_b, co_b;
  logic [1:0] win_b;
  logic       rv_b, busy_b;
`ifdef SPIKE_RATE_ALARM_EN
  logic [5:0] thresh_a;
  logic       alarm_a;
  logic [2:0] thresh_b;
  logic       alarm_b;
`endif

  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  spike_rate_monitor #(.WINDOW_CYCLES(16), .COUNT_W(6)) u_a (
    .clk(clk), .reset(rst_n), .enable(en_a),
    .spike_1(s1_a), .spike_2(s2_a), .spike_3(s3_a), .spike_output(so_a),
    .in_count_1(c1_a), .in_count_2(c2_a), .in_count_3(c3_a), .out_count(co_a),
    .winner(win_a), .result_valid(rv_a), .busy(busy_a)
`ifdef SPIKE_RATE_ALARM_EN
    , .rate_thresh(thresh_a), .rate_alarm(alarm_a)
`endif
  );

  spike_rate_monitor #(.WINDOW_CYCLES(32), .COUNT_W(3)) u_b (
    .clk(clk), .reset(rst_n), .enable(en_b),
    .spike_1(s1_b), .spike_2(s2_b), .spike_3(s3_b), .spike_output(so_b),
    .in_count_1(c1_b), .in_count_2(c2_b), .in_count_3(c3_b), .out_count(co_b),
    .winner(win_b), .result_valid(rv_b), .busy(busy_b)
`ifdef SPIKE_RATE_ALARM_EN
    , .rate_thresh(thresh_b), .rate_alarm(alarm_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [3:0] v);
    {so_a, s3_a, s2_a, s1_a} = v;
  endtask

  task automatic drive_b(input logic [3:0] v);
    {so_b, s3_b, s2_b, s1_b} = v;
  endtask

  // Bit k of each pattern is the line level during window cycle k.
  task automatic run_window_a(input logic [15:0] p1, input logic [15:0] p2,
                              input logic [15:0] p3, input logic [15:0] po);
    logic [15:0] r1, r2, r3, ro;
    r1 = p1; r2 = p2; r3 = p3; ro = po;
    for (int k = 0; k < 16; k++) begin
      drive_a({ro[0], r3[0], r2[0], r1[0]});
      r1 = r1 >> 1; r2 = r2 >> 1; r3 = r3 >> 1; ro = ro >> 1;
      tick();
      if (k < 15) check("a_rv_mid_window", 32'(rv_a), 0);
    end
    drive_a(4'b0000);
  endtask

  task automatic run_window_b(input logic [31:0] p1, input logic [31:0] p2,
                              input logic [31:0] p3, input logic [31:0] po);
    logic [31:0] r1, r2, r3, ro;
    r1 = p1; r2 = p2; r3 = p3; ro = po;
    for (int k = 0; k < 32; k++) begin
      drive_b({ro[0], r3[0], r2[0], r1[0]});
      r1 = r1 >> 1; r2 = r2 >> 1; r3 = r3 >> 1; ro = ro >> 1;
      tick();
      if (k < 31) check("b_rv_mid_window", 32'(rv_b), 0);
    end
    drive_b(4'b0000);
  endtask

  task automatic check_a(input string tag, input int c1, input int c2, input int c3,
                         input int co, input int w);
    check({tag, "_cnt1"},   32'(c1_a),  32'(c1));
    check({tag, "_cnt2"},   32'(c2_a),  32'(c2));
    check({tag, "_cnt3"},   32'(c3_a),  32'(c3));
    check({tag, "_cntout"}, 32'(co_a),  32'(co));
    check({tag, "_winner"}, 32'(win_a), 32'(w));
  endtask

  task automatic check_b(input string tag, input int c1, input int c2, input int c3,
                         input int co, input int w);
    check({tag, "_cnt1"},   32'(c1_b),  32'(c1));
    check({tag, "_cnt2"},   32'(c2_b),  32'(c2));
    check({tag, "_cnt3"},   32'(c3_b),  32'(c3));
    check({tag, "_cntout"}, 32'(co_b),  32'(co));
    check({tag, "_winner"}, 32'(win_b), 32'(w));
  endtask

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    drive_a(4'b0000);
    drive_b(4'b0000);
`ifdef SPIKE_RATE_ALARM_EN
    thresh_a = 6'd0;
    thresh_b = 3'd0;
`endif

    // Reset state
    repeat (3) tick();
    check_a("a_reset", 0, 0, 0, 0, 0);
    check_b("b_reset", 0, 0, 0, 0, 0);
    check("reset_flags", 32'({rv_a, busy_a, rv_b, busy_b}), 0);
`ifdef SPIKE_RATE_ALARM_EN
    check("a_reset_alarm", 32'(alarm_a), 0);
`endif

    // Idle with enable low for 100 cycles
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_flags", 32'({rv_a, busy_a, rv_b, busy_b}), 0);
    end
    check_a("a_idle", 0, 0, 0, 0, 0);

    // Basic window: 5/3/0/2 pulses, winner 1
    en_a = 1'b1;
    tick();
    check("a_busy_count", 32'(busy_a), 1);
    run_window_a(16'h02AA, 16'h0444, 16'h0000, 16'h1010);
    check("a_w1_rv", 32'(rv_a), 1);
    check("a_w1_busy", 32'(busy_a), 1);
    check_a("a_w1", 5, 3, 0, 2, 1);

    // Pulse during REPORT is ignored; next window starts immediately after
    s1_a = 1'b1;
    tick();
    check("a_rv_after_report", 32'(rv_a), 0);
    check("a_busy_after_report", 32'(busy_a), 1);

    // spike_2 held 10 cycles counts once; spike_3 at first and last cycles
    run_window_a(16'h0000, 16'h1FF8, 16'h8001, 16'h0000);
    check("a_w2_rv", 32'(rv_a), 1);
    check_a("a_w2", 0, 1, 2, 0, 3);

    // Abort at wcnt=8
    tick();
    for (int k = 0; k < 8; k++) begin
      drive_a({(k == 2), 1'b0, 1'b0, (k == 1) || (k == 3) || (k == 5)});
      tick();
    end
    drive_a(4'b0000);
    en_a = 1'b0;
    tick();
    check("a_abort_busy", 32'(busy_a), 0);
    check("a_abort_rv", 32'(rv_a), 0);
    check_a("a_abort_hold", 0, 1, 2, 0, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_abort_idle_rv", 32'(rv_a), 0);
    end

    // Re-enable: fresh window, aborted pulses not carried over
    en_a = 1'b1;
    tick();
    run_window_a(16'h0005, 16'h0000, 16'h0000, 16'h0000);
    check("a_w3_rv", 32'(rv_a), 1);
    check_a("a_w3", 2, 0, 0, 0, 1);
    tick();

`ifdef SPIKE_RATE_ALARM_EN
    thresh_a = 6'd2;
    run_window_a(16'h0000, 16'h0000, 16'h0000, 16'h0022);
    check("a_al1_cntout", 32'(co_a), 2);
    check("a_al1_alarm", 32'(alarm_a), 1);
    tick();
    run_window_a(16'h0000, 16'h0000, 16'h0000, 16'h0002);
    check("a_al2_cntout", 32'(co_a), 1);
    check("a_al2_alarm", 32'(alarm_a), 0);
    tick();
    thresh_a = 6'd0;
    run_window_a(16'h0000, 16'h0000, 16'h0000, 16'h2222);
    check("a_al3_cntout", 32'(co_a), 4);
    check("a_al3_alarm", 32'(alarm_a), 0);
    tick();
`endif
    en_a = 1'b0;
    tick();

    // Instance B: saturation at 7 with a 1-vs-3 tie
    en_b = 1'b1;
    tick();
    run_window_b(32'h33333333, 32'h0, 32'h33333333, 32'h5);
    check("b_w1_rv", 32'(rv_b), 1);
    check_b("b_sat", 7, 0, 7, 2, 1);
    tick();

    // All-zero window
    run_window_b(32'h0, 32'h0, 32'h0, 32'h0);
    check("b_w2_rv", 32'(rv_b), 1);
    check_b("b_zero", 0, 0, 0, 0, 0);
    tick();

    // 2-vs-3 tie above neuron 1
    run_window_b(32'h1, 32'h15, 32'h15, 32'h0);
    check("b_w3_rv", 32'(rv_b), 1);
    check_b("b_tie23", 1, 3, 3, 0, 2);
    en_b = 1'b0;
    tick();
    check("b_report_to_idle_busy", 32'(busy_b), 0);
    check("b_report_to_idle_rv", 32'(rv_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
